// File: rtl/vending_pkg.sv
`timescale 1ns/1ps
// Shared vending definitions: coin encodings, coin values, product costs and
// the change dispenser state enum.
package vending_pkg;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_2  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;
  localparam logic [1:0] COIN_10 = 2'b11;

  localparam logic [7:0] COST_A = 8'd15;
  localparam logic [7:0] COST_B = 8'd20;
  localparam logic [7:0] COST_C = 8'd35;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_REQUEST, ST_RELEASE, ST_DONE, ST_FAULT
  } disp_state_e;

  function automatic logic [7:0] coin_value(input logic [1:0] sel);
    case (sel)
      COIN_1:  coin_value = 8'd1;
      COIN_2:  coin_value = 8'd2;
      COIN_5:  coin_value = 8'd5;
      default: coin_value = 8'd10;
    endcase
  endfunction

endpackage

// File: rtl/coin_inventory.sv
`timescale 1ns/1ps
// Four per-denomination coin counters with saturating refill and a single
// decrement port; reports which denominations are in stock.
module coin_inventory #(
  parameter logic [7:0] INIT_COUNT = 8'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [7:0] refill_count,
  input  logic       dec,
  input  logic [1:0] dec_sel,
  output logic [3:0] nonzero
);

  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [8:0] sum   [4];

  // Refill and decrement are combined before saturating, so a coincident
  // refill and payout of the same coin nets to +refill_count-1.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = {1'b0, cnt_q[i]}
             + ((refill && refill_sel == 2'(i)) ? {1'b0, refill_count} : 9'd0)
             - ((dec && dec_sel == 2'(i)) ? 9'd1 : 9'd0);
      cnt_d[i]   = sum[i][8] ? 8'hFF : sum[i][7:0];
      nonzero[i] = (cnt_q[i] != 8'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= INIT_COUNT;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/change_dispenser.sv
`timescale 1ns/1ps
// Greedy coin-by-coin change payout to a hopper over a four-phase req/ack
// handshake, with inventory tracking, jam timeout and shortfall reporting.
module change_dispenser
  import vending_pkg::*;
#(
  parameter logic [7:0] INIT_COUNT  = 8'd20,
  parameter int         ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       change_valid,
  input  logic [7:0] change_amount,
  output logic       change_ready,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  input  logic [7:0] refill_count,
  input  logic       clear_fault,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic       jam,
  output logic [7:0] shortfall,
  output logic [7:0] coins_out
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  disp_state_e   state_q, state_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [7:0]    coins_q, coins_d;
  logic [7:0]    short_q, short_d;
  logic [1:0]    sel_q, sel_d;
  logic          jam_q, jam_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    nonzero;
  logic          dec;
  logic          pick_ok;
  logic [1:0]    pick;
  logic          tmo_hit;

  coin_inventory #(.INIT_COUNT(INIT_COUNT)) u_inv (
    .clk          (clk),
    .rst_n        (rst_n),
    .refill       (refill),
    .refill_sel   (refill_sel),
    .refill_count (refill_count),
    .dec          (dec),
    .dec_sel      (sel_q),
    .nonzero      (nonzero)
  );

  always_comb begin
    pick_ok = 1'b1;
    if (remaining_q >= 8'd10 && nonzero[3])     pick = COIN_10;
    else if (remaining_q >= 8'd5 && nonzero[2]) pick = COIN_5;
    else if (remaining_q >= 8'd2 && nonzero[1]) pick = COIN_2;
    else if (remaining_q >= 8'd1 && nonzero[0]) pick = COIN_1;
    else begin
      pick    = COIN_1;
      pick_ok = 1'b0;
    end
  end

  assign tmo_hit = (tmo_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
      coins_q     <= 8'd0;
      short_q     <= 8'd0;
      sel_q       <= COIN_1;
      jam_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coins_q     <= coins_d;
      short_q     <= short_d;
      sel_q       <= sel_d;
      jam_q       <= jam_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coins_d     = coins_q;
    short_d     = short_q;
    sel_d       = sel_q;
    jam_d       = jam_q;
    tmo_d       = tmo_q;
    dec         = 1'b0;
    case (state_q)
      ST_IDLE: if (change_valid) begin
        remaining_d = change_amount;
        coins_d     = 8'd0;
        state_d     = (change_amount == 8'd0) ? ST_DONE : ST_SELECT;
      end
      ST_SELECT: if (pick_ok) begin
        sel_d   = pick;
        tmo_d   = '0;
        state_d = ST_REQUEST;
      end else begin
        short_d = remaining_q;
        jam_d   = 1'b0;
        state_d = ST_FAULT;
      end
      ST_REQUEST: if (coin_ack) begin
        dec         = 1'b1;
        remaining_d = remaining_q - coin_value(sel_q);
        coins_d     = (coins_q == 8'hFF) ? coins_q : coins_q + 8'd1;
        tmo_d       = '0;
        state_d     = ST_RELEASE;
      end else if (tmo_hit) begin
        short_d = remaining_q;
        jam_d   = 1'b1;
        state_d = ST_FAULT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      ST_RELEASE: if (!coin_ack) begin
        state_d = (remaining_q == 8'd0) ? ST_DONE : ST_SELECT;
      end else if (tmo_hit) begin
        short_d = remaining_q;
        jam_d   = 1'b1;
        state_d = ST_FAULT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAULT: if (clear_fault) begin
        jam_d   = 1'b0;
        short_d = 8'd0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    change_ready = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    coin_req     = (state_q == ST_REQUEST);
    done         = (state_q == ST_DONE);
    fault        = (state_q == ST_FAULT);
    coin_sel     = sel_q;
    jam          = jam_q;
    shortfall    = short_q;
    coins_out    = coins_q;
  end

endmodule
